// File: rtl/sdram_arb.sv
// Round-robin arbiter for two clients in front of the sdram controller.
// It also runs the auto-refresh scheduler that drives the controller's refresh toggle.
module sdram_arb #(
  parameter int REFRESH_CYCLES = 780
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [26:1] a_addr,
  input  logic [15:0] a_din,
  input  logic [1:0]  a_bs,
  output logic [15:0] a_dout,
  output logic        a_ack,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [26:1] b_addr,
  input  logic [15:0] b_din,
  input  logic [1:0]  b_bs,
  output logic [15:0] b_dout,
  output logic        b_ack,
  output logic        sd_sel,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic [26:1] sd_addr,
  output logic [15:0] sd_din,
  output logic [1:0]  sd_bs,
  input  logic        sd_ready,
  input  logic [15:0] sd_dout,
  output logic        sd_refresh
);

  localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RGAP = 3'd1,
    REQ  = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          rfsh_pend_r, rfsh_pend_s;
  logic          last_r, last_s;   // 1 = B
  logic          gnt_r, gnt_s;     // 1 = B
  logic          sd_sel_s, sd_rd_s, sd_wr_s, sd_refresh_s;
  logic [26:1]   sd_addr_s;
  logic [15:0]   sd_din_s, a_dout_s, b_dout_s;
  logic [1:0]    sd_bs_s;
  logic          a_ack_s, b_ack_s;
  logic          pick_b_s, grant_we_s, wrap_s, rfsh_clr_s;

  // Next-state and next-output logic.
  always_comb begin
    state_s      = state_r;
    last_s       = last_r;
    gnt_s        = gnt_r;
    sd_sel_s     = sd_sel;
    sd_rd_s      = sd_rd;
    sd_wr_s      = sd_wr;
    sd_addr_s    = sd_addr;
    sd_din_s     = sd_din;
    sd_bs_s      = sd_bs;
    sd_refresh_s = sd_refresh;
    a_dout_s     = a_dout;
    b_dout_s     = b_dout;
    a_ack_s      = a_ack;
    b_ack_s      = b_ack;
    rfsh_clr_s   = 1'b0;
    wrap_s       = (cnt_r == CNT_MAX);
    // On a tie the client that was not served last wins.
    pick_b_s     = b_req & (~a_req | ~last_r);
    grant_we_s   = pick_b_s ? b_we : a_we;

    if (wrap_s) cnt_s = '0;
    else        cnt_s = cnt_r + CW'(1);

    case (state_r)
      IDLE: begin
        if (!sd_ready) begin
          state_s = IDLE;
        end else if (rfsh_pend_r) begin
          sd_refresh_s = ~sd_refresh;
          rfsh_clr_s   = 1'b1;
          state_s      = RGAP;
        end else if (a_req | b_req) begin
          last_s    = pick_b_s;
          gnt_s     = pick_b_s;
          sd_addr_s = pick_b_s ? b_addr : a_addr;
          sd_din_s  = pick_b_s ? b_din : a_din;
          if (grant_we_s) sd_bs_s = pick_b_s ? b_bs : a_bs;
          else            sd_bs_s = 2'b11;
          sd_sel_s  = 1'b1;
          sd_wr_s   = grant_we_s;
          sd_rd_s   = ~grant_we_s;
          state_s   = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      RGAP: state_s = IDLE;
      REQ: begin
        if (!sd_ready) begin
          sd_sel_s = 1'b0;
          sd_rd_s  = 1'b0;
          sd_wr_s  = 1'b0;
          state_s  = WAIT;
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        if (sd_ready) begin
          if (gnt_r) begin
            b_dout_s = sd_dout;
            b_ack_s  = 1'b1;
          end else begin
            a_dout_s = sd_dout;
            a_ack_s  = 1'b1;
          end
          state_s = DONE;
        end else begin
          state_s = WAIT;
        end
      end
      DONE: begin
        a_ack_s = 1'b0;
        b_ack_s = 1'b0;
        state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase

    // A wrap in the same cycle as service starts a fresh period.
    if (wrap_s)          rfsh_pend_s = 1'b1;
    else if (rfsh_clr_s) rfsh_pend_s = 1'b0;
    else                 rfsh_pend_s = rfsh_pend_r;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      rfsh_pend_r <= 1'b0;
      last_r      <= 1'b1;
      gnt_r       <= 1'b0;
      sd_sel      <= 1'b0;
      sd_rd       <= 1'b0;
      sd_wr       <= 1'b0;
      sd_addr     <= 26'd0;
      sd_din      <= 16'd0;
      sd_bs       <= 2'b00;
      sd_refresh  <= 1'b0;
      a_dout      <= 16'd0;
      b_dout      <= 16'd0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      rfsh_pend_r <= rfsh_pend_s;
      last_r      <= last_s;
      gnt_r       <= gnt_s;
      sd_sel      <= sd_sel_s;
      sd_rd       <= sd_rd_s;
      sd_wr       <= sd_wr_s;
      sd_addr     <= sd_addr_s;
      sd_din      <= sd_din_s;
      sd_bs       <= sd_bs_s;
      sd_refresh  <= sd_refresh_s;
      a_dout      <= a_dout_s;
      b_dout      <= b_dout_s;
      a_ack       <= a_ack_s;
      b_ack       <= b_ack_s;
    end
  end

endmodule

// File: tb/tb_sdram_arb.sv
// Directed bench for sdram_arb with a small behavioural model of the sdram controller's
// ready/refresh handshake (write 2 clocks, read 5 clocks, refresh 6 clocks plus a 3-cycle tail).
module tb_sdram_arb;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [26:1] a_addr = 26'd0, b_addr = 26'd0;
  logic [15:0] a_din = 16'd0, b_din = 16'd0;
  logic [1:0]  a_bs = 2'b00, b_bs = 2'b00;
  logic [15:0] a_dout, b_dout;
  logic        a_ack, b_ack;
  logic        sd_sel, sd_rd, sd_wr, sd_refresh;
  logic [26:1] sd_addr;
  logic [15:0] sd_din;
  logic [1:0]  sd_bs;
  logic        sd_ready;
  logic [15:0] sd_dout;

  logic        mdl_ready = 1'b1;
  logic [15:0] mdl_dout = 16'd0;
  logic [15:0] mdl_rdata = 16'hBEEF;
  logic        rf_prev = 1'b0;
  logic        busy_rf = 1'b0, busy_rd = 1'b0;
  int          busy = 0, tail = 0, accepts = 0;

  int total = 0;
  int bad = 0;

  assign sd_ready = mdl_ready;
  assign sd_dout  = mdl_dout;

  always #5 clk = ~clk;

  sdram_arb dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_bs(a_bs),
    .a_dout(a_dout), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_bs(b_bs),
    .b_dout(b_dout), .b_ack(b_ack),
    .sd_sel(sd_sel), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_addr(sd_addr),
    .sd_din(sd_din), .sd_bs(sd_bs), .sd_ready(sd_ready), .sd_dout(sd_dout),
    .sd_refresh(sd_refresh)
  );

  // Controller model: accepts on the first edge it sees sel with ready high and no tail left.
  always @(posedge clk) begin
    rf_prev <= sd_refresh;
    if (busy != 0) begin
      if (busy == 1) begin
        mdl_ready <= 1'b1;
        if (busy_rf)      tail <= 3;
        else if (busy_rd) mdl_dout <= mdl_rdata;
      end
      busy <= busy - 1;
    end else if (mdl_ready) begin
      if (sd_refresh !== rf_prev) begin
        mdl_ready <= 1'b0;
        busy      <= 6;
        busy_rf   <= 1'b1;
      end else if (tail != 0) begin
        tail <= tail - 1;
      end else if (sd_sel === 1'b1) begin
        accepts   <= accepts + 1;
        mdl_ready <= 1'b0;
        busy_rf   <= 1'b0;
        busy_rd   <= sd_rd;
        busy      <= (sd_rd === 1'b1) ? 5 : 2;
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (16) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    bit got;
    a_req = 1'b1; a_we = 1'b0; a_addr = 26'h2345678; a_bs = 2'b01;
    reset_n = 1'b0;
    repeat (16) @(negedge clk);
    total++;
    if ({sd_sel, sd_rd, sd_wr, sd_addr, sd_din, sd_bs, sd_refresh, a_ack, b_ack, a_dout, b_dout} !== 80'd0) begin
      bad++;
      $display("FAIL reset_outputs got sel=%b rd=%b wr=%b addr=%h ref=%b acks=%b%b want all zero",
               sd_sel, sd_rd, sd_wr, sd_addr, sd_refresh, a_ack, b_ack);
    end
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if ({sd_sel, sd_rd, sd_wr} !== 3'b110) begin
      bad++; $display("FAIL reset_release_strobes got=%b want=110", {sd_sel, sd_rd, sd_wr});
    end
    total++;
    if (sd_addr !== 26'h2345678) begin
      bad++; $display("FAIL reset_release_addr got=%h want=2345678", sd_addr);
    end
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_ack) begin got = 1'b1; a_req = 1'b0; break; end
    end
    a_req = 1'b0;
    total++;
    if (!got) begin bad++; $display("FAIL reset_first_ack got=none want=ack"); end
  endtask

  task automatic test_read_a();
    int lat, acks, backs;
    logic [15:0] dout;
    do_reset();
    mdl_rdata = 16'hBEEF;
    a_we = 1'b0; a_addr = 26'h123456; a_bs = 2'b00; a_req = 1'b1;
    lat = -1; acks = 0; backs = 0; dout = 16'd0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) begin
        total++;
        if ({sd_sel, sd_rd, sd_wr, sd_bs} !== 5'b11011) begin
          bad++; $display("FAIL read_a_strobes got=%b want=11011", {sd_sel, sd_rd, sd_wr, sd_bs});
        end
      end
      if (b_ack) backs++;
      if (a_ack) begin
        acks++;
        if (lat < 0) begin lat = i - 1; dout = a_dout; end
        a_req = 1'b0;
      end
    end
    total++;
    if (lat != 7) begin bad++; $display("FAIL read_a_latency got=%0d want=7", lat); end
    total++;
    if (dout !== 16'hBEEF) begin bad++; $display("FAIL read_a_dout got=%h want=beef", dout); end
    total++;
    if (acks != 1 || backs != 0) begin
      bad++; $display("FAIL read_a_ack_count got a=%0d b=%0d want a=1 b=0", acks, backs);
    end
  endtask

  task automatic test_write_b();
    int lat, acks;
    do_reset();
    b_we = 1'b1; b_bs = 2'b01; b_din = 16'h00A5; b_addr = 26'h0000042; b_req = 1'b1;
    lat = -1; acks = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) begin
        total++;
        if ({sd_sel, sd_rd, sd_wr, sd_bs} !== 5'b10101) begin
          bad++; $display("FAIL write_b_strobes got=%b want=10101", {sd_sel, sd_rd, sd_wr, sd_bs});
        end
        total++;
        if (sd_din !== 16'h00A5 || sd_addr !== 26'h0000042) begin
          bad++; $display("FAIL write_b_data got din=%h addr=%h want din=00a5 addr=0000042", sd_din, sd_addr);
        end
      end
      if (b_ack) begin
        acks++;
        if (lat < 0) lat = i - 1;
        b_req = 1'b0;
      end
    end
    total++;
    if (lat != 4) begin bad++; $display("FAIL write_b_latency got=%0d want=4", lat); end
    total++;
    if (acks != 1) begin bad++; $display("FAIL write_b_ack_count got=%0d want=1", acks); end
  endtask

  task automatic test_contention();
    logic order [6];
    int n, dual, extra;
    do_reset();
    a_we = 1'b0; a_addr = 26'h0000100;
    b_we = 1'b1; b_addr = 26'h0000200; b_din = 16'h1111; b_bs = 2'b11;
    a_req = 1'b1; b_req = 1'b1;
    n = 0; dual = 0; extra = 0;
    for (int k = 0; k < 6; k++) order[k] = 1'b0;
    for (int i = 0; i < 200 && n < 6; i++) begin
      @(negedge clk);
      if (a_ack && b_ack) dual++;
      if (a_ack && n < 6) begin order[n] = 1'b0; n++; end
      if (b_ack && n < 6) begin order[n] = 1'b1; n++; end
    end
    a_req = 1'b0; b_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_ack || b_ack) extra++;
    end
    total++;
    if (n != 6 || dual != 0 || extra != 0) begin
      bad++; $display("FAIL contention_acks got n=%0d dual=%0d extra=%0d want 6/0/0", n, dual, extra);
    end
    for (int k = 0; k < 6; k++) begin
      total++;
      if (order[k] !== k[0]) begin
        bad++; $display("FAIL contention_order[%0d] got=%s want=%s", k, order[k] ? "B" : "A", k[0] ? "B" : "A");
      end
    end
  endtask

  task automatic test_refresh_collision();
    int selc, acks, acc0;
    do_reset();
    a_we = 1'b0; a_addr = 26'h0000777;
    repeat (780) @(negedge clk);
    a_req = 1'b1;
    acc0 = accepts;
    selc = 0; acks = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        total++;
        if (sd_refresh !== 1'b1 || sd_sel !== 1'b0) begin
          bad++; $display("FAIL rfsh_first got refresh=%b sel=%b want refresh=1 sel=0", sd_refresh, sd_sel);
        end
      end
      if (sd_sel) selc++;
      if (a_ack) begin acks++; a_req = 1'b0; end
    end
    total++;
    if (selc != 4) begin bad++; $display("FAIL rfsh_req_hold got=%0d want=4", selc); end
    total++;
    if (acks != 1 || accepts - acc0 != 1) begin
      bad++; $display("FAIL rfsh_access got acks=%0d accepts=%0d want 1/1", acks, accepts - acc0);
    end
  endtask

  task automatic test_refresh_period();
    int tt [16];
    int nt;
    logic prev;
    do_reset();
    nt = 0;
    prev = sd_refresh;
    for (int i = 1; i <= 7805; i++) begin
      @(negedge clk);
      if (sd_refresh !== prev) begin
        if (nt < 16) tt[nt] = i;
        nt++;
        prev = sd_refresh;
      end
    end
    total++;
    if (nt != 10) begin bad++; $display("FAIL rfsh_count got=%0d want=10", nt); end
    total++;
    if (nt > 0 && tt[0] != 781) begin bad++; $display("FAIL rfsh_first_time got=%0d want=781", tt[0]); end
    for (int k = 1; k < 10 && k < nt; k++) begin
      total++;
      if (tt[k] - tt[k-1] != 780) begin
        bad++; $display("FAIL rfsh_spacing[%0d] got=%0d want=780", k, tt[k] - tt[k-1]);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int acks, rst_acks, acc0;
    logic [15:0] dout;
    do_reset();
    mdl_rdata = 16'h1234;
    acc0 = accepts;
    a_we = 1'b0; a_addr = 26'h0000055; a_req = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (sd_sel !== 1'b0 || accepts - acc0 != 1) begin
      bad++; $display("FAIL midrd_in_wait got sel=%b accepts=%0d want 0/1", sd_sel, accepts - acc0);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({sd_sel, sd_rd, sd_wr, sd_addr, sd_refresh, a_ack, a_dout} !== 48'd0) begin
      bad++; $display("FAIL midrd_reset_outputs got sel=%b addr=%h ack=%b want zero", sd_sel, sd_addr, a_ack);
    end
    rst_acks = 0;
    repeat (2) begin
      @(negedge clk);
      if (a_ack) rst_acks++;
    end
    reset_n = 1'b1;
    acks = 0; dout = 16'd0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (a_ack) begin acks++; dout = a_dout; a_req = 1'b0; end
    end
    a_req = 1'b0;
    total++;
    if (rst_acks != 0 || acks != 1) begin
      bad++; $display("FAIL midrd_acks got during=%0d after=%0d want 0/1", rst_acks, acks);
    end
    total++;
    if (accepts - acc0 != 2 || dout !== 16'h1234) begin
      bad++; $display("FAIL midrd_rerequest got accepts=%0d dout=%h want 2/1234", accepts - acc0, dout);
    end
  endtask

  initial begin
    #1 reset_n = 1'b0;
    test_reset();
    test_read_a();
    test_write_b();
    test_contention();
    test_refresh_collision();
    test_refresh_period();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
